// File: rtl/sudoku_checker.sv
// 4x4 Sudoku board validator.
// Scans 4 rows, 4 columns and 4 boxes, one group per clock.
module sudoku_checker #(
    parameter int CELL_W     = 3,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic                  clka,
    input  logic                  restart,
    input  logic                  dp_check,
    input  logic [16*CELL_W-1:0]  board,
    output logic                  busy,
    output logic                  done,
    output logic                  solved,
    output logic [3:0]            fail_group
);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_t;

    state_t                state_q, state_d;
    logic [3:0]            g_q, g_d;
    logic [16*CELL_W-1:0]  snap_q, snap_d;
    logic [3:0]            fg_d;
    logic                  solved_d;

    logic [3:0]            cell_idx [4];
    logic [CELL_W-1:0]     cell_val [4];
    logic [3:0]            seen;
    logic                  legal;
    logic                  pass;
    logic                  first_fail;

    // Cell index is {row, col}; boxes interleave box and in-box bits.
    always_comb begin
        for (int j = 0; j < 4; j++) begin
            cell_idx[j] = '0;
            unique case (1'b1)
                (g_q[3:2] == 2'd0): cell_idx[j] = {g_q[1:0], j[1:0]};
                (g_q[3:2] == 2'd1): cell_idx[j] = {j[1:0], g_q[1:0]};
                default:            cell_idx[j] = {g_q[1], j[1], g_q[0], j[0]};
            endcase
            cell_val[j] = snap_q[CELL_W*cell_idx[j] +: CELL_W];
        end
    end

    always_comb begin
        seen  = 4'b0000;
        legal = 1'b1;
        for (int j = 0; j < 4; j++) begin
            unique case (cell_val[j])
                CELL_W'(1): seen[0] = 1'b1;
                CELL_W'(2): seen[1] = 1'b1;
                CELL_W'(3): seen[2] = 1'b1;
                CELL_W'(4): seen[3] = 1'b1;
                default:    legal   = 1'b0;
            endcase
        end
        pass = legal && (seen == 4'b1111);
    end

    assign first_fail = !pass && (fail_group == 4'hF);

    always_comb begin
        state_d  = state_q;
        g_d      = g_q;
        snap_d   = snap_q;
        fg_d     = fail_group;
        solved_d = solved;
        unique case (state_q)
            IDLE: begin
                if (dp_check) begin
                    snap_d   = board;
                    g_d      = 4'd0;
                    solved_d = 1'b0;
                    fg_d     = 4'hF;
                    state_d  = SCAN;
                end
            end
            SCAN: begin
                if (first_fail) begin
                    fg_d = g_q;
                end
                if ((EARLY_EXIT && !pass) || (g_q == 4'd11)) begin
                    state_d  = DONE;
                    solved_d = pass && (fail_group == 4'hF);
                end else begin
                    g_d = g_q + 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clka or posedge restart) begin
        if (restart) begin
            state_q    <= IDLE;
            g_q        <= 4'd0;
            snap_q     <= '0;
            fail_group <= 4'h0;
            solved     <= 1'b0;
        end else begin
            state_q    <= state_d;
            g_q        <= g_d;
            snap_q     <= snap_d;
            fail_group <= fg_d;
            solved     <= solved_d;
        end
    end

    assign busy = (state_q == SCAN);
    assign done = (state_q == DONE);

endmodule

// File: tb/tb_sudoku_checker.sv
// Scoreboard bench for sudoku_checker.
// Runs an early-exit and a full-scan instance side by side.
module tb_sudoku_checker;

    localparam int CW = 3;

    typedef struct {
        int         start;
        int         lat;
        logic       slv;
        logic [3:0] fg;
    } item_t;

    logic            clka = 1'b0;
    logic            restart;
    logic            dp_check;
    logic [16*CW-1:0] board;
    logic [1:0]      busy, done, solved;
    logic [3:0]      fg0, fg1;

    int    cyc = 0;
    int    n_vec = 0;
    int    n_bad = 0;
    int    bcnt [2];
    item_t q0 [$];
    item_t q1 [$];

    sudoku_checker #(.CELL_W(CW), .EARLY_EXIT(1'b1)) u_ee (
        .clka       (clka),
        .restart    (restart),
        .dp_check   (dp_check),
        .board      (board),
        .busy       (busy[0]),
        .done       (done[0]),
        .solved     (solved[0]),
        .fail_group (fg0)
    );

    sudoku_checker #(.CELL_W(CW), .EARLY_EXIT(1'b0)) u_full (
        .clka       (clka),
        .restart    (restart),
        .dp_check   (dp_check),
        .board      (board),
        .busy       (busy[1]),
        .done       (done[1]),
        .solved     (solved[1]),
        .fail_group (fg1)
    );

    always #5 clka = ~clka;

    always @(posedge clka) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    // Cell i takes the low CW bits of hex nibble i, nibble 0 leftmost.
    function automatic logic [16*CW-1:0] mk(input logic [63:0] h);
        logic [16*CW-1:0] b;
        b = '0;
        for (int i = 0; i < 16; i++) b[CW*i +: CW] = h[60-4*i +: CW];
        return b;
    endfunction

    always @(negedge clka) begin
        if (restart) begin
            bcnt = '{0, 0};
        end else begin
            for (int d = 0; d < 2; d++) begin
                item_t it;
                logic [3:0] fg;
                fg = (d == 0) ? fg0 : fg1;
                if (busy[d]) bcnt[d]++;
                if (done[d]) begin
                    int qs;
                    qs = (d == 0) ? q0.size() : q1.size();
                    chk($sformatf("unexpected_done%0d", d), qs > 0, 1);
                    if (qs > 0) begin
                        if (d == 0) it = q0.pop_front();
                        else        it = q1.pop_front();
                        chk($sformatf("latency%0d", d),
                            cyc - it.start, it.lat);
                        chk($sformatf("busy_cycles%0d", d),
                            bcnt[d], it.lat - 1);
                        chk($sformatf("solved%0d", d),
                            int'(solved[d]), int'(it.slv));
                        chk($sformatf("fail_group%0d", d),
                            int'(fg), int'(it.fg));
                    end
                    bcnt[d] = 0;
                end
            end
        end
    end

    task automatic issue(input logic [63:0] h, input logic s,
                         input int l0, input int l1,
                         input logic [3:0] f0, input logic [3:0] f1);
        item_t a, b;
        board    = mk(h);
        dp_check = 1'b1;
        a = '{cyc, l0, s, f0};
        b = '{cyc, l1, s, f1};
        q0.push_back(a);
        q1.push_back(b);
        @(posedge clka);
        #1 dp_check = 1'b0;
    endtask

    task automatic settle();
        repeat (16) @(posedge clka);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_busy"},   int'(busy),   0);
        chk({tag, "_done"},   int'(done),   0);
        chk({tag, "_solved"}, int'(solved), 0);
        chk({tag, "_fg0"},    int'(fg0),    0);
        chk({tag, "_fg1"},    int'(fg1),    0);
    endtask

    localparam logic [63:0] VALID = 64'h1234_3412_2143_4321;
    localparam logic [63:0] SWAP  = 64'h1234_4312_2143_4321;
    localparam logic [63:0] EMPTY = 64'h1234_3412_2143_4320;
    localparam logic [63:0] ILLEG = 64'h5234_3412_2143_4321;

    initial begin
        restart  = 1'b1;
        dp_check = 1'b0;
        board    = '0;
        #1;
        chk_reset_vals("reset");
        repeat (2) @(posedge clka);
        #1 restart = 1'b0;
        @(posedge clka);
        #1;

        issue(VALID, 1'b1, 13, 13, 4'hF, 4'hF);
        chk("busy_after_accept", int'(busy), 3);
        settle();
        chk("solved_held", int'(solved), 3);
        chk("fg_held0", int'(fg0), 15);
        chk("fg_held1", int'(fg1), 15);

        issue(SWAP, 1'b0, 6, 13, 4'd4, 4'd4);
        settle();
        issue(EMPTY, 1'b0, 5, 13, 4'd3, 4'd3);
        settle();
        issue(ILLEG, 1'b0, 2, 13, 4'd0, 4'd0);
        settle();

        // Board wiped after capture, extra request while scanning.
        issue(VALID, 1'b1, 13, 13, 4'hF, 4'hF);
        repeat (2) @(posedge clka);
        #1 board = '0;
        repeat (2) @(posedge clka);
        #1 dp_check = 1'b1;
        @(posedge clka);
        #1 dp_check = 1'b0;
        settle();

        // Abort mid-scan.
        issue(VALID, 1'b1, 13, 13, 4'hF, 4'hF);
        repeat (3) @(posedge clka);
        #2 restart = 1'b1;
        #1;
        chk_reset_vals("abort");
        q0.delete();
        q1.delete();
        repeat (2) @(posedge clka);
        #1 restart = 1'b0;
        settle();
        chk("post_abort_idle", int'(busy), 0);

        chk("queue_empty", q0.size() + q1.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got %0d expected %0d", 1, 0);
        $fatal(1, "timeout");
    end

endmodule
